// File: rtl/tile_fetcher_pkg.sv
// Shared constants and state encoding for the tile fetcher and the scanline
// renderer that will sit on top of it.
package tile_fetcher_pkg;

    localparam int unsigned AddrW         = 16;
    localparam int unsigned DataW         = 8;
    localparam int unsigned TileCoordW    = 5;
    localparam int unsigned LineW         = 3;
    localparam int unsigned ColourW       = 4;
    localparam int unsigned PaletteW      = 2;
    localparam int unsigned PixelW        = PaletteW + ColourW;
    localparam int unsigned RowW          = 32;
    localparam int unsigned PixCntW       = 3;

    // Memory layout of map and pattern data
    localparam int unsigned MapEntryBytes = 2;
    localparam int unsigned MapRowStride  = 64;
    localparam int unsigned TileBytes     = 32;
    localparam int unsigned RowBytes      = 4;

    localparam logic [AddrW-1:0] DefaultMapBase     = 16'h0000;
    localparam logic [AddrW-1:0] DefaultPatternBase = 16'h2000;

    // Attribute byte fields
    localparam int unsigned AttrFlipHBit  = 7;
    localparam int unsigned AttrFlipVBit  = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAP_IDX  = 3'd1,
        MAP_ATTR = 3'd2,
        PAT0     = 3'd3,
        PAT1     = 3'd4,
        PAT2     = 3'd5,
        PAT3     = 3'd6,
        EMIT     = 3'd7
    } fetch_state_e;

endpackage

// File: rtl/tile_row_shifter.sv
// Holds one 4bpp tile row (byte0 in the top byte) and presents its pixels in
// order, reversed when flip_h_i is set.
//   byte_we_i/byte_sel_i/byte_i : load one pattern byte; loading byte 3 rewinds
//   advance_i                   : step to the next pixel
//   colour_o                    : registered colour of the current pixel
//   last_c                      : current pixel is the 8th one
module tile_row_shifter
    import tile_fetcher_pkg::*;
(
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               byte_we_i,
    input  logic [1:0]         byte_sel_i,
    input  logic [DataW-1:0]   byte_i,
    input  logic               flip_h_i,
    input  logic               advance_i,
    output logic [ColourW-1:0] colour_o,
    output logic               last_c
);

    logic [RowW-1:0]    row_q, row_d;
    logic [PixCntW-1:0] cnt_q, cnt_d;
    logic [PixCntW-1:0] sel;
    logic [ColourW-1:0] colour_q, colour_d;

    // Colour is looked up from the next row/counter so it is ready the cycle
    // after the last byte loads.
    always_comb begin
        row_d = row_q;
        cnt_d = cnt_q;
        if (byte_we_i) begin
            case (byte_sel_i)
                2'd0:    row_d[31:24] = byte_i;
                2'd1:    row_d[23:16] = byte_i;
                2'd2:    row_d[15:8]  = byte_i;
                default: row_d[7:0]   = byte_i;
            endcase
        end
        if (byte_we_i && (byte_sel_i == 2'd3)) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = cnt_q + 3'd1;
        end
        sel      = flip_h_i ? ~cnt_d : cnt_d;
        // Pixel k sits at nibble (7-k) counting from the LSB
        colour_d = row_d[{~sel, 2'b00} +: ColourW];
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q    <= '0;
            cnt_q    <= '0;
            colour_q <= '0;
        end else begin
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
        end
    end

    assign colour_o = colour_q;
    assign last_c   = (cnt_q == 3'd7);

endmodule

// File: rtl/tile_fetcher.sv
// Fetches one 8-pixel row of a 4bpp tile: reads the map entry (index, attr),
// then the four pattern bytes, then streams pixels over valid/ready.
//   clk, reset (async, active-low)
//   start, tileX, tileY, line : row request, accepted only in IDLE
//   memAddress / memData      : RAM read port, data combinational
//   pixel, pixelValid, pixelReady : {palette, colour} stream
//   busy, done                : activity flag and end-of-row pulse
module tile_fetcher
    import tile_fetcher_pkg::*;
#(
    parameter logic [AddrW-1:0] MapBase     = DefaultMapBase,
    parameter logic [AddrW-1:0] PatternBase = DefaultPatternBase
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TileCoordW-1:0] tileX,
    input  logic [TileCoordW-1:0] tileY,
    input  logic [LineW-1:0]      line,
    output logic [AddrW-1:0]      memAddress,
    input  logic [DataW-1:0]      memData,
    output logic [PixelW-1:0]     pixel,
    output logic                  pixelValid,
    input  logic                  pixelReady,
    output logic                  busy,
    output logic                  done
);

    fetch_state_e          state_q, state_d;
    logic [DataW-1:0]      index_q, index_d;
    logic                  flip_h_q, flip_h_d;
    logic [PaletteW-1:0]   palette_q, palette_d;
    logic [LineW-1:0]      line_q, line_d;
    logic [AddrW-1:0]      addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LineW-1:0]      row_sel;
    logic                  handshake;
    logic                  byte_we;
    logic [1:0]            byte_sel;
    logic [ColourW-1:0]    colour;
    logic                  last_pix;

    // Next state; the address register is loaded with the address of the
    // state being entered so memAddress is registered yet aligned to it.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        flip_h_d  = flip_h_q;
        palette_d = palette_q;
        line_d    = line_q;
        addr_d    = '0;
        done_d    = 1'b0;
        byte_we   = 1'b0;
        byte_sel  = 2'd0;
        row_sel   = line_q;
        handshake = (state_q == EMIT) && pixelReady;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAP_IDX;
                    line_d  = line;
                    addr_d  = MapBase + 16'(tileY * MapRowStride)
                                      + 16'(tileX * MapEntryBytes);
                end
            end
            MAP_IDX: begin
                index_d = memData;
                addr_d  = addr_q + 16'd1;
                state_d = MAP_ATTR;
            end
            MAP_ATTR: begin
                flip_h_d  = memData[AttrFlipHBit];
                palette_d = memData[PaletteW-1:0];
                row_sel   = memData[AttrFlipVBit] ? ~line_q : line_q;
                addr_d    = PatternBase + 16'(index_q * TileBytes)
                                        + 16'(row_sel * RowBytes);
                state_d   = PAT0;
            end
            PAT0, PAT1, PAT2: begin
                byte_we  = 1'b1;
                byte_sel = 2'(state_q - PAT0);
                addr_d   = addr_q + 16'd1;
                state_d  = fetch_state_e'(state_q + 3'd1);
            end
            PAT3: begin
                byte_we  = 1'b1;
                byte_sel = 2'd3;
                state_d  = EMIT;
            end
            EMIT: begin
                if (handshake && last_pix) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == EMIT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            flip_h_q  <= 1'b0;
            palette_q <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            flip_h_q  <= flip_h_d;
            palette_q <= palette_d;
            line_q    <= line_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    tile_row_shifter u_shifter (
        .clk        (clk),
        .rst_ni     (reset),
        .byte_we_i  (byte_we),
        .byte_sel_i (byte_sel),
        .byte_i     (memData),
        .flip_h_i   (flip_h_q),
        .advance_i  (handshake),
        .colour_o   (colour),
        .last_c     (last_pix)
    );

    assign memAddress = addr_q;
    assign pixel      = {palette_q, colour};
    assign pixelValid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tile_fetcher.sv
// Bench for tile_fetcher: RAM model, directed rows, random rows, stalls and
// asynchronous reset in the middle of a fetch.
module tb_tile_fetcher;

    localparam int MAP_BASE = 16'h0000;
    localparam int PAT_BASE = 16'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  tileX = '0;
    logic [4:0]  tileY = '0;
    logic [2:0]  line = '0;
    logic [15:0] memAddress;
    logic [7:0]  memData;
    logic [5:0]  pixel;
    logic        pixelValid;
    logic        pixelReady = 1'b0;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    assign memData = mem[memAddress];

    always #5 clk = ~clk;

    tile_fetcher dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tileX      (tileX),
        .tileY      (tileY),
        .line       (line),
        .memAddress (memAddress),
        .memData    (memData),
        .pixel      (pixel),
        .pixelValid (pixelValid),
        .pixelReady (pixelReady),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: map entry -> attribute rules -> pattern bytes -> pixel order
    function automatic void model_row(input logic [4:0] tx, input logic [4:0] ty,
                                      input logic [2:0] ln,
                                      output logic [47:0] ep, output logic [95:0] ea);
        logic [15:0] ma, pa;
        logic [7:0]  idx, attr, b;
        logic [2:0]  r;
        int          src;
        ma  = 16'(MAP_BASE + int'(ty) * 64 + int'(tx) * 2);
        idx = mem[ma];
        attr = mem[16'(ma + 16'd1)];
        r   = attr[6] ? 3'(7 - int'(ln)) : ln;
        pa  = 16'(PAT_BASE + int'(idx) * 32 + int'(r) * 4);
        ea[15:0]  = ma;
        ea[31:16] = 16'(ma + 16'd1);
        for (int n = 0; n < 4; n++) ea[(n+2)*16 +: 16] = 16'(int'(pa) + n);
        for (int p = 0; p < 8; p++) begin
            src = attr[7] ? 7 - p : p;
            b   = mem[16'(int'(pa) + src / 2)];
            ep[p*6 +: 6] = {attr[1:0], (src % 2 == 0) ? b[7:4] : b[3:0]};
        end
    endfunction

    function automatic logic ready_for(input int mode, input int j);
        case (mode)
            0:       return 1'b1;
            1:       return (j % 4 == 0) || (j % 4 == 3);
            default: return ($urandom_range(3) != 0);
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},  48'(memAddress), 48'h0);
        check({tag, "_pixel"}, 48'(pixel),      48'h0);
        check({tag, "_valid"}, 48'(pixelValid), 48'h0);
        check({tag, "_busy"},  48'(busy),       48'h0);
        check({tag, "_done"},  48'(done),       48'h0);
    endtask

    // One full row: addresses each fetch cycle, pixels through EMIT, done pulse
    task automatic fetch_row(input logic [4:0] tx, input logic [4:0] ty, input logic [2:0] ln,
                             input int mode, input logic [47:0] ep, input logic [95:0] ea);
        int k;
        int cyc;
        @(negedge clk);
        start = 1'b1; tileX = tx; tileY = ty; line = ln;
        pixelReady = 1'($urandom_range(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(1));
            tileX = 5'($urandom); tileY = 5'($urandom); line = 3'($urandom);
            check($sformatf("addr%0d", i), 48'(memAddress), 48'(ea[i*16 +: 16]));
            check("fetch_valid", 48'(pixelValid), 48'h0);
            check("fetch_busy", 48'(busy), 48'h1);
        end
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 64) begin
            @(negedge clk);
            check("emit_valid", 48'(pixelValid), 48'h1);
            check($sformatf("pix%0d", k), 48'(pixel), 48'(ep[k*6 +: 6]));
            check("emit_addr", 48'(memAddress), 48'h0);
            check("emit_done", 48'(done), 48'h0);
            pixelReady = ready_for(mode, cyc);
            start = 1'($urandom_range(1));
            if (pixelReady) k++;
            cyc++;
        end
        check("handshakes", 48'(k), 48'd8);
        @(negedge clk);
        start = 1'b0;
        pixelReady = 1'($urandom_range(1));
        check("done_pulse", 48'(done), 48'h1);
        check("done_busy", 48'(busy), 48'h0);
        check("done_valid", 48'(pixelValid), 48'h0);
        check("done_addr", 48'(memAddress), 48'h0);
        @(negedge clk);
        check("done_single", 48'(done), 48'h0);
        check("idle_busy", 48'(busy), 48'h0);
    endtask

    // Start a row and pull reset low asynchronously after n cycles
    task automatic reset_mid(input int n, input string tag);
        @(negedge clk);
        start = 1'b1; tileX = 5'd1; tileY = 5'd1; line = 3'd2;
        pixelReady = 1'b1;
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1 check_idle_outputs(tag);
        @(negedge clk);
        check_idle_outputs({tag, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] ep;
        logic [95:0] ea;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        // Reset state
        #1 check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Plain tile 0 row 0
        mem[16'h2000] = 8'h0E; mem[16'h2001] = 8'h80;
        mem[16'h2002] = 8'h88; mem[16'h2003] = 8'h00;
        ea = {16'h2003, 16'h2002, 16'h2001, 16'h2000, 16'h0001, 16'h0000};
        ep = {6'h00, 6'h00, 6'h08, 6'h08, 6'h00, 6'h08, 6'h0E, 6'h00};
        fetch_row(5'd0, 5'd0, 3'd0, 0, ep, ea);

        // Horizontal flip, palette 1
        mem[16'h0001] = 8'h81;
        ep = {6'h10, 6'h1E, 6'h18, 6'h10, 6'h18, 6'h18, 6'h10, 6'h10};
        fetch_row(5'd0, 5'd0, 3'd0, 0, ep, ea);

        // Vertical flip, palette 2: line 0 reads pattern row 7
        mem[16'h0001] = 8'h42;
        mem[16'h201C] = 8'h12; mem[16'h201D] = 8'h34;
        mem[16'h201E] = 8'h56; mem[16'h201F] = 8'h78;
        ea = {16'h201F, 16'h201E, 16'h201D, 16'h201C, 16'h0001, 16'h0000};
        ep = {6'h28, 6'h27, 6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21};
        fetch_row(5'd0, 5'd0, 3'd0, 0, ep, ea);

        // Map column/row addressing, tile index 5, line 5
        mem[16'h0086] = 8'h05; mem[16'h0087] = 8'h00;
        mem[16'h20B4] = 8'hA1; mem[16'h20B5] = 8'hB2;
        mem[16'h20B6] = 8'hC3; mem[16'h20B7] = 8'hD4;
        ea = {16'h20B7, 16'h20B6, 16'h20B5, 16'h20B4, 16'h0087, 16'h0086};
        ep = {6'h04, 6'h0D, 6'h03, 6'h0C, 6'h02, 6'h0B, 6'h01, 6'h0A};
        fetch_row(5'd3, 5'd2, 3'd5, 0, ep, ea);

        // Stall pattern 1,0,0,1 with start pulses during busy
        fetch_row(5'd3, 5'd2, 3'd5, 1, ep, ea);

        // Random RAM contents, random rows and ready patterns
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int t = 0; t < 12; t++) begin
            logic [4:0] tx, ty;
            logic [2:0] ln;
            tx = 5'($urandom); ty = 5'($urandom); ln = 3'($urandom);
            model_row(tx, ty, ln, ep, ea);
            fetch_row(tx, ty, ln, t % 3, ep, ea);
        end

        // Asynchronous reset during PAT2, then a clean fetch
        reset_mid(5, "rst_pat2");
        model_row(5'd7, 5'd9, 3'd4, ep, ea);
        fetch_row(5'd7, 5'd9, 3'd4, 0, ep, ea);

        // Asynchronous reset mid-EMIT, then a clean fetch
        reset_mid(9, "rst_emit");
        model_row(5'd30, 5'd31, 3'd6, ep, ea);
        fetch_row(5'd30, 5'd31, 3'd6, 2, ep, ea);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
